// File: rtl/rom_bank_fetch_ctrl_pkg.sv
// Shared types and constants for the ROM bank fetch front end.
package rom_pkg;

  localparam int unsigned ROM_ADDR_W = 14;
  localparam int unsigned ROM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  // Bank index width; a single bank still carries one (constant zero) bit.
  function automatic int unsigned bank_width(input int unsigned num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

endpackage

// File: rtl/rom_bank_fetch_ctrl_if.sv
// CPU-side ROM bus plus backing-memory request bus for rom_bank_fetch_ctrl.
interface rom_bank_fetch_ctrl_if
  import rom_pkg::*;
#(
  parameter int unsigned ADDR_W    = ROM_ADDR_W,
  parameter int unsigned DATA_W    = ROM_DATA_W,
  parameter int unsigned NUM_BANKS = 2,
  localparam int unsigned BANK_W   = bank_width(NUM_BANKS)
);

  // CPU side
  logic [ADDR_W-1:0]        A;
  logic [NUM_BANKS-1:0]     CS_b;
  logic                     OE_b;
  logic [DATA_W-1:0]        Dout;
  logic                     dout_en;
  logic                     rdy;
  logic                     bank_conflict;

  // Backing memory side
  logic                     mem_req;
  logic [BANK_W+ADDR_W-1:0] mem_addr;
  logic                     mem_ack;
  logic                     mem_valid;
  logic [DATA_W-1:0]        mem_rdata;

  // Controller view
  modport slave (
    input  A, CS_b, OE_b, mem_ack, mem_valid, mem_rdata,
    output Dout, dout_en, rdy, bank_conflict, mem_req, mem_addr
  );

  // CPU plus memory model view
  modport master (
    output A, CS_b, OE_b, mem_ack, mem_valid, mem_rdata,
    input  Dout, dout_en, rdy, bank_conflict, mem_req, mem_addr
  );

endinterface

// File: rtl/rom_cs_decode.sv
// Active-low chip-select priority encoder: lowest selected bank wins.
module rom_cs_decode
  import rom_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 2,
  localparam int unsigned BANK_W   = bank_width(NUM_BANKS)
) (
  input  logic [NUM_BANKS-1:0] cs_b_i,
  output logic [BANK_W-1:0]    bank_o,
  output logic                 any_sel_o,
  output logic                 multi_sel_o
);

  // Scan from the top so the lowest active index is written last.
  always_comb begin
    bank_o      = '0;
    any_sel_o   = 1'b0;
    multi_sel_o = 1'b0;
    for (int i = int'(NUM_BANKS) - 1; i >= 0; i--) begin
      if (!cs_b_i[i]) begin
        multi_sel_o = multi_sel_o | any_sel_o;
        any_sel_o   = 1'b1;
        bank_o      = BANK_W'(i);
      end
    end
  end

endmodule

// File: rtl/rom_bank_fetch_ctrl.sv
// Bus front end for banked ROM chips served from one variable-latency memory.
// A one-entry hit register answers repeat reads without stalling the CPU.
module rom_bank_fetch_ctrl
  import rom_pkg::*;
#(
  parameter int unsigned ADDR_W    = ROM_ADDR_W,
  parameter int unsigned DATA_W    = ROM_DATA_W,
  parameter int unsigned NUM_BANKS = 2,
  localparam int unsigned BANK_W   = bank_width(NUM_BANKS)
) (
  input logic                  clk,
  input logic                  rst_b,
  rom_bank_fetch_ctrl_if.slave bus
);

  localparam int unsigned KeyW = BANK_W + ADDR_W;

  fetch_state_t      state_q, state_d;
  logic [KeyW-1:0]   mem_addr_q, mem_addr_d;
  logic [KeyW-1:0]   hit_key_q, hit_key_d;
  logic              hit_vld_q, hit_vld_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              conflict_q, conflict_d;

  logic [BANK_W-1:0] bank;
  logic              any_sel;
  logic              multi_sel;
  logic              sel;
  logic [KeyW-1:0]   key;
  logic              hit;
  logic              fill;

  rom_cs_decode #(
    .NUM_BANKS(NUM_BANKS)
  ) u_cs_decode (
    .cs_b_i     (bus.CS_b),
    .bank_o     (bank),
    .any_sel_o  (any_sel),
    .multi_sel_o(multi_sel)
  );

  assign sel = any_sel & ~bus.OE_b;
  assign key = {bank, bus.A};
  assign hit = hit_vld_q && (key == hit_key_q);

  // Fetch sequencing: one outstanding request, never cancelled once issued.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    fill       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel && !hit) begin
          state_d    = REQ;
          mem_addr_d = key;
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          // Data arriving with the ack completes the fetch in one step.
          if (bus.mem_valid) begin
            fill    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.mem_valid) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Hit register load on fill and sticky multi-select flag.
  always_comb begin
    hit_vld_d  = hit_vld_q | fill;
    hit_key_d  = fill ? mem_addr_q : hit_key_q;
    dout_d     = fill ? bus.mem_rdata : dout_q;
    conflict_d = conflict_q | multi_sel;
  end

  // State and data registers; reset abandons any fetch in flight.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
      hit_key_q  <= '0;
      hit_vld_q  <= 1'b0;
      dout_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      hit_key_q  <= hit_key_d;
      hit_vld_q  <= hit_vld_d;
      dout_q     <= dout_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.mem_req       = (state_q == REQ);
  assign bus.mem_addr      = mem_addr_q;
  assign bus.Dout          = dout_q;
  assign bus.dout_en       = sel & hit;
  assign bus.rdy           = ~sel | hit;
  assign bus.bank_conflict = conflict_q;

endmodule

// File: tb/tb_rom_bank_fetch_ctrl.sv
// Directed, table-driven and randomized checks for rom_bank_fetch_ctrl.
module tb_rom_bank_fetch_ctrl;
  import rom_pkg::*;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 8;
  localparam int unsigned NB = 2;
  localparam int unsigned KW = 15;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  rom_bank_fetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_BANKS(NB)) bus ();

  rom_bank_fetch_ctrl #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .NUM_BANKS(NB)
  ) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cpu(input logic [1:0] cs, input logic oe, input logic [13:0] a);
    bus.CS_b = cs;
    bus.OE_b = oe;
    bus.A    = a;
  endtask

  function automatic logic [7:0] mem_fn(input logic [KW-1:0] k);
    return 8'((32'(k) * 37 + 11) & 255);
  endfunction

  typedef struct {
    logic [1:0]  cs_b;
    logic        oe_b;
    logic [13:0] a;
    logic        rdy;
    logic        en;
    logic [7:0]  dout;
  } vec_t;

  vec_t vecs[8];

  // Random-phase reference state
  bit          m_vld;
  logic [KW-1:0] m_key;
  logic [7:0]  m_data;
  bit          m_conf;
  int          mem_phase;
  int          ack_dly;
  int          val_dly;
  logic [KW-1:0] mem_key;
  bit          real_valid;
  int          stall;
  logic [13:0] pool[4];

  initial begin
    rst_b         = 1'b0;
    bus.A         = '0;
    bus.CS_b      = 2'b11;
    bus.OE_b      = 1'b1;
    bus.mem_ack   = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_rdata = '0;

    // Reset state
    #2;
    check("rst_rdy", bus.rdy, 1);
    check("rst_req", bus.mem_req, 0);
    check("rst_en", bus.dout_en, 0);
    check("rst_dout", bus.Dout, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_conf", bus.bank_conflict, 0);
    tick();
    tick();
    rst_b = 1'b1;
    tick();

    // Cold miss, bank 0
    drive_cpu(2'b10, 1'b0, 14'h0123);
    #1;
    check("miss_rdy0", bus.rdy, 0);
    check("miss_en0", bus.dout_en, 0);
    tick();
    check("miss_req", bus.mem_req, 1);
    check("miss_addr", bus.mem_addr, 15'h0123);
    check("miss_rdy1", bus.rdy, 0);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("miss_req_drop", bus.mem_req, 0);
    check("miss_rdy2", bus.rdy, 0);
    tick();
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 8'hA5;
    check("miss_rdy_wait", bus.rdy, 0);
    tick();
    bus.mem_valid = 1'b0;
    check("fill_rdy", bus.rdy, 1);
    check("fill_en", bus.dout_en, 1);
    check("fill_dout", bus.Dout, 8'hA5);

    // Repeat read hits with no new request
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hit_rdy", bus.rdy, 1);
      check("hit_req", bus.mem_req, 0);
    end

    // Same A on bank 1 misses; ack and valid together fill at once
    drive_cpu(2'b01, 1'b0, 14'h0123);
    #1;
    check("b1_rdy0", bus.rdy, 0);
    tick();
    check("b1_req", bus.mem_req, 1);
    check("b1_addr", bus.mem_addr, 15'h4123);
    bus.mem_ack   = 1'b1;
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 8'h3C;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_valid = 1'b0;
    check("av_rdy", bus.rdy, 1);
    check("av_dout", bus.Dout, 8'h3C);
    check("av_req", bus.mem_req, 0);

    // Address changes while the first fetch is outstanding
    drive_cpu(2'b10, 1'b0, 14'h0010);
    tick();
    check("mc_addr0", bus.mem_addr, 15'h0010);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    bus.A       = 14'h0011;
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 8'h11;
    tick();
    bus.mem_valid = 1'b0;
    check("mc_dout0", bus.Dout, 8'h11);
    check("mc_rdy0", bus.rdy, 0);
    check("mc_en0", bus.dout_en, 0);
    tick();
    check("mc_req1", bus.mem_req, 1);
    check("mc_addr1", bus.mem_addr, 15'h0011);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 8'h22;
    check("mc_rdy1", bus.rdy, 0);
    tick();
    bus.mem_valid = 1'b0;
    check("mc_rdy2", bus.rdy, 1);
    check("mc_dout1", bus.Dout, 8'h22);

    // Combinational output table against held entry {bank0, 14'h0011} = 8'h22
    vecs[0] = '{2'b10, 1'b0, 14'h0011, 1'b1, 1'b1, 8'h22};
    vecs[1] = '{2'b11, 1'b0, 14'h0011, 1'b1, 1'b0, 8'h22};
    vecs[2] = '{2'b10, 1'b1, 14'h0011, 1'b1, 1'b0, 8'h22};
    vecs[3] = '{2'b01, 1'b1, 14'h0011, 1'b1, 1'b0, 8'h22};
    vecs[4] = '{2'b01, 1'b0, 14'h0011, 1'b0, 1'b0, 8'h22};
    vecs[5] = '{2'b00, 1'b0, 14'h0011, 1'b1, 1'b1, 8'h22};
    vecs[6] = '{2'b10, 1'b0, 14'h0012, 1'b0, 1'b0, 8'h22};
    vecs[7] = '{2'b11, 1'b1, 14'h1234, 1'b1, 1'b0, 8'h22};
    for (int i = 0; i < 8; i++) begin
      drive_cpu(vecs[i].cs_b, vecs[i].oe_b, vecs[i].a);
      #0.5;
      check($sformatf("tbl%0d_rdy", i), bus.rdy, vecs[i].rdy);
      check($sformatf("tbl%0d_en", i), bus.dout_en, vecs[i].en);
      check($sformatf("tbl%0d_dout", i), bus.Dout, vecs[i].dout);
      check($sformatf("tbl%0d_req", i), bus.mem_req, 0);
    end

    // Two selects low: bank 0 served, conflict sticks
    tick();
    drive_cpu(2'b00, 1'b0, 14'h0011);
    #1;
    check("cf_rdy", bus.rdy, 1);
    check("cf_en", bus.dout_en, 1);
    check("cf_pre", bus.bank_conflict, 0);
    tick();
    check("cf_set", bus.bank_conflict, 1);
    drive_cpu(2'b11, 1'b0, 14'h0011);
    tick();
    check("cf_sticky", bus.bank_conflict, 1);
    check("cf_desel_en", bus.dout_en, 0);

    // Output disabled: no drive, no stall, no request
    drive_cpu(2'b10, 1'b1, 14'h3FFF);
    #1;
    check("oe_rdy", bus.rdy, 1);
    check("oe_en", bus.dout_en, 0);
    tick();
    check("oe_req", bus.mem_req, 0);

    // Async reset while waiting for data; a late valid is not filled
    drive_cpu(2'b10, 1'b0, 14'h0200);
    tick();
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    #2;
    rst_b = 1'b0;
    #1;
    check("ar_req", bus.mem_req, 0);
    check("ar_en", bus.dout_en, 0);
    check("ar_dout", bus.Dout, 0);
    check("ar_addr", bus.mem_addr, 0);
    check("ar_conf", bus.bank_conflict, 0);
    bus.CS_b = 2'b11;
    #1;
    check("ar_rdy", bus.rdy, 1);
    tick();
    tick();
    rst_b = 1'b1;
    drive_cpu(2'b10, 1'b0, 14'h0200);
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 8'h77;
    tick();
    bus.mem_valid = 1'b0;
    check("late_dout", bus.Dout, 0);
    check("late_rdy", bus.rdy, 0);
    check("late_req", bus.mem_req, 1);
    bus.mem_ack   = 1'b1;
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 8'h77;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_valid = 1'b0;
    check("late_fill", bus.Dout, 8'h77);
    check("late_rdy1", bus.rdy, 1);

    // Randomized run against the reference model
    drive_cpu(2'b11, 1'b1, 14'h0000);
    rst_b = 1'b0;
    tick();
    rst_b     = 1'b1;
    m_vld     = 0;
    m_key     = '0;
    m_data    = '0;
    m_conf    = 0;
    mem_phase = 0;
    ack_dly   = 0;
    val_dly   = 0;
    mem_key   = '0;
    real_valid = 0;
    stall     = 0;
    pool[0] = 14'h0000;
    pool[1] = 14'h0001;
    pool[2] = 14'h2AAA;
    pool[3] = 14'h3FFF;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      if (real_valid) begin
        m_vld  = 1;
        m_key  = mem_key;
        m_data = mem_fn(mem_key);
      end
      if (bus.CS_b == 2'b00) m_conf = 1;
      #1;
      // Memory responder: ack after a random delay, data 0..3 cycles later
      bus.mem_ack   = 1'b0;
      bus.mem_valid = 1'b0;
      real_valid    = 0;
      if (mem_phase == 0 && bus.mem_req) begin
        if (ack_dly == 0) begin
          bus.mem_ack = 1'b1;
          mem_key     = bus.mem_addr;
          val_dly     = $urandom_range(0, 3);
          if (val_dly == 0) begin
            bus.mem_valid = 1'b1;
            bus.mem_rdata = mem_fn(mem_key);
            real_valid    = 1;
            ack_dly       = $urandom_range(0, 2);
          end else begin
            mem_phase = 1;
          end
        end else begin
          ack_dly--;
        end
      end else if (mem_phase == 1) begin
        val_dly--;
        if (val_dly == 0) begin
          bus.mem_valid = 1'b1;
          bus.mem_rdata = mem_fn(mem_key);
          real_valid    = 1;
          mem_phase     = 0;
          ack_dly       = $urandom_range(0, 2);
        end
      end else if ($urandom_range(0, 15) == 0) begin
        // Stray data pulse with nothing accepted; must be ignored
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 8'($urandom);
      end
      // CPU: new access mostly when not stalled
      if ((bus.rdy && $urandom_range(0, 3) == 0) || $urandom_range(0, 31) == 0) begin
        int r;
        r = $urandom_range(0, 15);
        if (r < 7) bus.CS_b = 2'b10;
        else if (r < 13) bus.CS_b = 2'b01;
        else if (r < 15) bus.CS_b = 2'b11;
        else bus.CS_b = 2'b00;
        bus.OE_b = ($urandom_range(0, 4) == 0);
        bus.A    = pool[$urandom_range(0, 3)];
      end
      @(negedge clk);
      begin
        logic          sel;
        logic [KW-1:0] key;
        logic          hit;
        sel = (bus.CS_b != 2'b11) && !bus.OE_b;
        key = {(bus.CS_b[0] ? 1'b1 : 1'b0), bus.A};
        hit = m_vld && (m_key == key);
        check("rnd_rdy", bus.rdy, !sel || hit);
        check("rnd_en", bus.dout_en, sel && hit);
        check("rnd_dout", bus.Dout, m_vld ? m_data : 8'h00);
        check("rnd_conf", bus.bank_conflict, m_conf);
        if (!bus.rdy) stall++;
        else stall = 0;
        if (stall > 60) begin
          check("rnd_stall_bound", stall, 60);
          break;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
